bch_encode_parallel: RTL and testbench

//  Systematic binary BCH encoder. This is the transmit-side counterpart of the decode chain (syndrome,
//  key-equation solver, Chien search). It accepts K message bits, BITS per cycle, through a valid/ready handshake.
//  It forwards the message words unchanged, then appends P = bch_ecc_bits(M,T) parity bits, BITS per cycle.
//  The parity is the remainder of m(x)*x^P mod g(x), computed by a parallel (BITS-wide lookahead) LFSR.

---
 rtl/bch_encode_parallel_pkg.sv | 112 +++++++++++
 rtl/bch_encode_parallel_if.sv | 23 ++
 rtl/lfsr_parallel_step.sv | 24 ++
 rtl/bch_encode_parallel.sv | 123 ++++++++++++
 tb/tb_bch_encode_parallel.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bch_encode_parallel_pkg.sv
// rtl/bch_encode_parallel_pkg.sv - BCH code constants: generator polynomial, parity width, legality check
// All functions are elaboration-time helpers for M in 3..10.
package bch_encode_parallel_pkg;

  localparam int GMAX = 128;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  // Smallest r >= 1 with 2**r >= v.
  function automatic int log2(input int v);
    int r;
    r = 30;
    for (int i = 30; i >= 1; i--) begin
      if ((1 << i) >= v) r = i;
    end
    return r;
  endfunction

  function automatic logic [15:0] prim_poly(input int m);
    case (m)
      3:       return 16'h000B;
      4:       return 16'h0013;
      5:       return 16'h0025;
      6:       return 16'h0043;
      7:       return 16'h0089;
      8:       return 16'h011D;
      9:       return 16'h0211;
      10:      return 16'h0409;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] gf_mul(input logic [15:0] a, input logic [15:0] b, input int m);
    logic [15:0] r;
    logic [15:0] pp;
    r  = '0;
    pp = prim_poly(m);
    for (int i = 15; i >= 0; i--) begin
      if (i < m) begin
        r = r << 1;
        if (r[m]) r = r ^ pp;
        if (b[i]) r = r ^ a;
      end
    end
    return r;
  endfunction

  // Product of the distinct minimal polynomials of a^1..a^(2T), x^P term included.
  function automatic logic [GMAX-1:0] bch_generator(input int m, input int t);
    logic [GMAX-1:0] g;
    logic [GMAX-1:0] acc;
    logic [15:0]     coef [0:16];
    logic [15:0]     root;
    logic [63:0]     covered;
    logic            done;
    int              n;
    int              e;
    n       = (1 << m) - 1;
    g       = 1;
    covered = '0;
    for (int i = 1; i <= 2 * t && i < 64; i++) begin
      if (!covered[i]) begin
        root = 16'd1;
        for (int j = 0; j < i; j++) root = gf_mul(root, 16'd2, m);
        for (int k = 0; k <= 16; k++) coef[k] = '0;
        coef[0] = 16'd1;
        e       = i;
        done    = 1'b0;
        // Walk the cyclotomic coset of i, multiplying in (x + a^e) for each member.
        for (int s = 0; s < 16; s++) begin
          if (!done) begin
            if (e < 64) covered[e] = 1'b1;
            for (int k = 16; k >= 1; k--) coef[k] = coef[k-1] ^ gf_mul(root, coef[k], m);
            coef[0] = gf_mul(root, coef[0], m);
            e    = (2 * e) % n;
            root = gf_mul(root, root, m);
            if (e == i) done = 1'b1;
          end
        end
        acc = '0;
        for (int k = 0; k <= 16; k++) begin
          if (coef[k][0]) acc = acc ^ (g << k);
        end
        g = acc;
      end
    end
    return g;
  endfunction

  function automatic int bch_ecc_bits(input int m, input int t);
    logic [GMAX-1:0] g;
    int deg;
    g   = bch_generator(m, t);
    deg = 0;
    for (int i = 0; i < GMAX; i++) begin
      if (g[i]) deg = i;
    end
    return deg;
  endfunction

  function automatic bit bch_legal(input int m, input int t, input int k, input int bits);
    int p;
    if (m < 3 || m > 10 || t < 1 || k < 1 || bits < 1) return 1'b0;
    p = bch_ecc_bits(m, t);
    return (k % bits == 0) && (k + p <= (1 << m) - 1) && (bits <= p);
  endfunction

endpackage

// File: rtl/bch_encode_parallel_if.sv
// rtl/bch_encode_parallel_if.sv - message input handshake and codeword output bundle
interface bch_encode_parallel_if #(
  parameter int BITS = 1
);
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_data;
  logic            out_valid;
  logic [BITS-1:0] out_data;
  logic            out_first;
  logic            out_last;
  logic            out_parity;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data, out_first, out_last, out_parity
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data, out_first, out_last, out_parity
  );
endinterface

// File: rtl/lfsr_parallel_step.sv
// rtl/lfsr_parallel_step.sv - BITS-wide lookahead of a Galois LFSR dividing by g(x)
// Combinational; g[P] is implicit and i_data[BITS-1] is consumed first.
module lfsr_parallel_step #(
  parameter int           P    = 8,
  parameter int           BITS = 1,
  parameter logic [P-1:0] G    = '0
) (
  input  logic [P-1:0]    i_state,
  input  logic [BITS-1:0] i_data,
  output logic [P-1:0]    o_next
);

  logic [P-1:0] w_acc;

  always_comb begin
    w_acc = i_state;
    for (int b = BITS - 1; b >= 0; b--) begin
      if (w_acc[P-1] ^ i_data[b]) w_acc = (w_acc << 1) ^ G;
      else                        w_acc = w_acc << 1;
    end
    o_next = w_acc;
  end

endmodule

// File: rtl/bch_encode_parallel.sv
// rtl/bch_encode_parallel.sv - systematic BCH encoder: forwards message words, then appends parity
// Parity is m(x)*x^P mod g(x), accumulated BITS per clock.
module bch_encode_parallel
  import bch_encode_parallel_pkg::*;
#(
  parameter int M    = 4,
  parameter int T    = 3,
  parameter int K    = 5,
  parameter int BITS = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  bch_encode_parallel_if.slave bus
);

  localparam int                P       = bch_ecc_bits(M, T);
  localparam logic [GMAX-1:0]   G_FULL  = bch_generator(M, T);
  localparam logic [P-1:0]      G       = G_FULL[P-1:0];
  localparam int                WORDS_K = K / BITS;
  localparam int                WORDS_P = (P + BITS - 1) / BITS;
  localparam int                WKW     = log2(WORDS_K + 1);
  localparam int                WPW     = log2(WORDS_P + 1);
  localparam logic [WKW-1:0]    LAST_K  = WKW'(WORDS_K - 1);
  localparam logic [WPW-1:0]    LAST_P  = WPW'(WORDS_P - 1);

  if (!bch_legal(M, T, K, BITS)) begin : g_illegal
    $error("bch_encode_parallel: illegal M/T/K/BITS combination");
  end

  state_t          r_state;
  logic [P-1:0]    r_lfsr;
  logic [WKW-1:0]  r_word_cnt;
  logic [WPW-1:0]  r_par_cnt;
  logic            r_out_valid;
  logic [BITS-1:0] r_out_data;
  logic            r_out_first;
  logic            r_out_last;
  logic            r_out_parity;

  logic            w_xfer;
  logic [P-1:0]    w_step_state;
  logic [P-1:0]    w_step_next;

  // A new codeword always starts from a clean remainder, whatever the register holds.
  assign w_step_state = (r_state == S_IDLE) ? '0 : r_lfsr;
  assign w_xfer       = bus.in_valid && bus.in_ready;

  lfsr_parallel_step #(
    .P    (P),
    .BITS (BITS),
    .G    (G)
  ) u_step (
    .i_state (w_step_state),
    .i_data  (bus.in_data),
    .o_next  (w_step_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_lfsr       <= '0;
      r_word_cnt   <= '0;
      r_par_cnt    <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_first  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_parity <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_out_first  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_parity <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_lfsr      <= w_step_next;
            r_word_cnt  <= WKW'(1);
            r_out_valid <= 1'b1;
            r_out_data  <= bus.in_data;
            r_out_first <= 1'b1;
            r_par_cnt   <= '0;
            if (WORDS_K == 1) r_state <= S_PARITY;
            else              r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_lfsr      <= w_step_next;
            r_word_cnt  <= r_word_cnt + WKW'(1);
            r_out_valid <= 1'b1;
            r_out_data  <= bus.in_data;
            if (r_word_cnt == LAST_K) begin
              r_state   <= S_PARITY;
              r_par_cnt <= '0;
            end
          end
        end
        S_PARITY: begin
          // Zero fill leaves the unused tail of the final word cleared.
          r_out_valid  <= 1'b1;
          r_out_parity <= 1'b1;
          r_out_data   <= r_lfsr[P-1 -: BITS];
          r_lfsr       <= r_lfsr << BITS;
          r_par_cnt    <= r_par_cnt + WPW'(1);
          if (r_par_cnt == LAST_P) begin
            r_out_last <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = rst_n && (r_state != S_PARITY);
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_first  = r_out_first;
  assign bus.out_last   = r_out_last;
  assign bus.out_parity = r_out_parity;

endmodule

// File: tb/tb_bch_encode_parallel.sv
// tb/tb_bch_encode_parallel.sv - bench for bch_encode_parallel against a long-division parity model
module tb_bch_encode_parallel;

  typedef struct {
    logic [3:0] d;
    logic       f;
    logic       l;
    logic       p;
    int         cyc;
  } obs_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;
  int   cyc;
  obs_t qa[$];
  obs_t qb[$];

  bch_encode_parallel_if #(.BITS(1)) ifa ();
  bch_encode_parallel_if #(.BITS(4)) ifb ();

  bch_encode_parallel #(.M(4), .T(2), .K(7), .BITS(1)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  bch_encode_parallel #(.M(5), .T(3), .K(16), .BITS(4)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    obs_t o;
    if (ifa.out_valid === 1'b1) begin
      o.d = {3'b000, ifa.out_data}; o.f = ifa.out_first; o.l = ifa.out_last;
      o.p = ifa.out_parity; o.cyc = cyc;
      qa.push_back(o);
    end
    if (ifb.out_valid === 1'b1) begin
      o.d = ifb.out_data; o.f = ifb.out_first; o.l = ifb.out_last;
      o.p = ifb.out_parity; o.cyc = cyc;
      qb.push_back(o);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Remainder of a(x) mod g(x) by schoolbook long division; top is deg bound of a.
  function automatic logic [63:0] poly_mod(input logic [63:0] a, input int top,
                                           input logic [63:0] g, input int p);
    logic [63:0] r;
    r = a;
    for (int i = top; i >= p; i--) begin
      if (r[i]) r = r ^ (g << (i - p));
    end
    return r;
  endfunction

  task automatic send_a(input logic [6:0] msg);
    int tmo;
    for (int i = 6; i >= 0; i--) begin
      ifa.in_valid = 1'b1;
      ifa.in_data  = msg[i];
      tmo = 0;
      do begin @(negedge clk); tmo++; end while (ifa.in_ready !== 1'b1 && tmo < 50);
      chk("a_ready_tmo", tmo < 50, 64'(tmo), 64'd50);
      @(posedge clk); #1;
    end
    ifa.in_valid = 1'b0;
  endtask

  task automatic check_a(input logic [6:0] msg, output logic [14:0] got);
    logic [63:0] r;
    logic [14:0] exp_cw;
    logic [3:0]  ov;
    logic [3:0]  ev;
    int          tmo;
    r      = poly_mod(64'(msg) << 8, 14, 64'h1D1, 8);
    exp_cw = {msg, r[7:0]};
    tmo    = 0;
    do begin @(negedge clk); tmo++; end while (qa.size() < 15 && tmo < 60);
    @(posedge clk); #1;
    chk("a_len", qa.size() === 15, 64'(qa.size()), 64'd15);
    got = '0;
    for (int i = 0; i < 15; i++) begin
      if (i < qa.size()) begin
        got[14-i] = qa[i].d[0];
        ov = {qa[i].d[0], qa[i].f, qa[i].l, qa[i].p};
        ev = {exp_cw[14-i], (i == 0), (i == 14), (i >= 7)};
        chk("a_word", ov === ev, 64'(ov), 64'(ev));
      end
    end
    qa.delete();
  endtask

  task automatic send_b(input logic [15:0] msg, input int nwords, input int gap_pct,
                        output int low);
    int  tmo;
    bit  done;
    low = 0;
    for (int w = 0; w < nwords; w++) begin
      tmo  = 0;
      done = 1'b0;
      while (!done && tmo < 100) begin
        ifb.in_valid = ($urandom_range(99) >= gap_pct);
        ifb.in_data  = ifb.in_valid ? msg[15 - 4*w -: 4] : 4'($urandom);
        @(negedge clk);
        tmo++;
        if (ifb.in_ready !== 1'b1) low++;
        done = (ifb.in_valid === 1'b1) && (ifb.in_ready === 1'b1);
        @(posedge clk); #1;
      end
      chk("b_ready_tmo", done === 1'b1, 64'(done), 64'd1);
    end
    ifb.in_valid = 1'b0;
  endtask

  task automatic run_batch_b(input int n, input int gap_pct, input bit contig);
    logic [15:0] msgs[$];
    logic [15:0] m;
    logic [63:0] r;
    logic [15:0] cw_p;
    logic [6:0]  ov;
    logic [6:0]  ev;
    int          low;
    int          tmo;
    int          idx;
    int          exp_low;
    qb.delete();
    for (int j = 0; j < n; j++) begin
      m = 16'($urandom);
      msgs.push_back(m);
      send_b(m, 4, gap_pct, low);
      exp_low = (j > 0) ? 4 : 0;
      chk("b_ready_low", low === exp_low, 64'(low), 64'(exp_low));
    end
    tmo = 0;
    do begin @(negedge clk); tmo++; end while (qb.size() < 8 * n && tmo < 100);
    @(posedge clk); #1;
    chk("b_len", qb.size() === 8 * n, 64'(qb.size()), 64'(8 * n));
    for (int j = 0; j < n; j++) begin
      r    = poly_mod(64'(msgs[j]) << 15, 30, 64'h8FAF, 15);
      cw_p = {r[14:0], 1'b0};
      for (int i = 0; i < 8; i++) begin
        idx = 8 * j + i;
        if (idx < qb.size()) begin
          ov = {qb[idx].d, qb[idx].f, qb[idx].l, qb[idx].p};
          ev = {(i < 4) ? msgs[j][15 - 4*i -: 4] : cw_p[15 - 4*(i-4) -: 4],
                (i == 0), (i == 7), (i >= 4)};
          chk("b_word", ov === ev, 64'(ov), 64'(ev));
          if (i == 7) chk("b_pad", qb[idx].d[0] === 1'b0, 64'(qb[idx].d[0]), 64'd0);
        end
      end
    end
    if (contig) begin
      for (int k = 1; k < qb.size(); k++)
        chk("b_contig", qb[k].cyc === qb[k-1].cyc + 1, 64'(qb[k].cyc), 64'(qb[k-1].cyc + 1));
    end
  endtask

  initial begin
    logic [14:0] got;
    logic [63:0] rem;
    logic [6:0]  ma;
    logic [6:0]  flags;
    int          low;
    n_vec = 0;
    n_fail = 0;
    rst_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_data = '0;
    ifb.in_valid = 1'b0; ifb.in_data = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", ifa.in_ready === 1'b0, 64'(ifa.in_ready), 64'd0);
    chk("rst_b_ready", ifb.in_ready === 1'b0, 64'(ifb.in_ready), 64'd0);
    chk("rst_a_valid", ifa.out_valid === 1'b0, 64'(ifa.out_valid), 64'd0);
    chk("rst_b_valid", ifb.out_valid === 1'b0, 64'(ifb.out_valid), 64'd0);
    flags = {ifb.out_first, ifb.out_last, ifb.out_parity, ifb.out_data};
    chk("rst_b_flags", flags === 7'h00, 64'(flags), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rel_a_ready", ifa.in_ready === 1'b1, 64'(ifa.in_ready), 64'd1);
    chk("rel_b_ready", ifb.in_ready === 1'b1, 64'(ifb.in_ready), 64'd1);
    @(posedge clk); #1;

    // Single-bit lane, generator 0x1D1.
    send_a(7'b0000001);
    check_a(7'b0000001, got);
    chk("a_unit_cw", got === 15'b0000001_11010001, 64'(got), 64'(15'b0000001_11010001));
    send_a(7'b0000000);
    check_a(7'b0000000, got);
    chk("a_zero_cw", got === 15'h0000, 64'(got), 64'd0);
    send_a(7'b1111111);
    check_a(7'b1111111, got);
    rem = poly_mod(64'(got), 14, 64'h1D1, 8);
    chk("a_ones_syndrome", rem === 64'h0, rem, 64'h0);
    for (int j = 0; j < 8; j++) begin
      ma = 7'($urandom);
      send_a(ma);
      check_a(ma, got);
    end

    // Four-bit lane, BCH(31,16): dense, gapped, back-to-back.
    run_batch_b(200, 0, 1'b0);
    run_batch_b(20, 50, 1'b0);
    run_batch_b(20, 0, 1'b1);

    // Abort after two of four message words.
    send_b(16'hA5C3, 2, 0, low);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", ifb.out_valid === 1'b0, 64'(ifb.out_valid), 64'd0);
    chk("abort_ready", ifb.in_ready === 1'b0, 64'(ifb.in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_batch_b(1, 0, 1'b0);
    run_batch_b(3, 30, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
